// File: rtl/connect_pkg.sv
// Shared encodings for the Connect-4 win scanner and the game FSM.
package connect_pkg;

    localparam logic [1:0] STILL_PLAYING = 2'b00;
    localparam logic [1:0] P1_WINS       = 2'b01;
    localparam logic [1:0] P2_WINS       = 2'b10;
    localparam logic [1:0] TIE           = 2'b11;

    localparam logic [1:0] DIR_H  = 2'b00;
    localparam logic [1:0] DIR_V  = 2'b01;
    localparam logic [1:0] DIR_DR = 2'b10;
    localparam logic [1:0] DIR_DL = 2'b11;

    typedef enum logic {StIdle, StScan} scan_state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/win_line_eval.sv
// Combinational line checker: for the given anchor, flags a win in each of H, V, DR, DL.
module win_line_eval
    import connect_pkg::*;
#(
    parameter int unsigned ROWS    = 6,
    parameter int unsigned COLS    = 7,
    parameter int unsigned WIN_LEN = 4,
    parameter int unsigned RW      = idx_width(ROWS),
    parameter int unsigned CW      = idx_width(COLS)
) (
    input  logic [ROWS*COLS-1:0] snap_board,
    input  logic [ROWS*COLS-1:0] snap_owner,
    input  logic [RW-1:0]        row,
    input  logic [CW-1:0]        col,
    output logic [3:0]           win,
    output logic [3:0]           owner
);

    logic [3:0] win_grid [ROWS][COLS];
    logic       own_grid [ROWS][COLS];

    // Lines that would leave the board are pruned here, so they can never report a win.
    for (genvar r = 0; r < int'(ROWS); r++) begin : g_row
        for (genvar c = 0; c < int'(COLS); c++) begin : g_col
            assign own_grid[r][c] = snap_owner[r*int'(COLS)+c];
            for (genvar d = 0; d < 4; d++) begin : g_dir
                localparam int DR = (d == 0) ? 0 : 1;
                localparam int DC = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
                localparam int ER = r + DR * (int'(WIN_LEN) - 1);
                localparam int EC = c + DC * (int'(WIN_LEN) - 1);
                if (ER < int'(ROWS) && EC >= 0 && EC < int'(COLS)) begin : g_in
                    logic [WIN_LEN-1:0] occ;
                    logic [WIN_LEN-1:0] own;
                    for (genvar i = 0; i < int'(WIN_LEN); i++) begin : g_cell
                        localparam int IDX = (r + DR * i) * int'(COLS) + c + DC * i;
                        assign occ[i] = snap_board[IDX];
                        assign own[i] = snap_owner[IDX];
                    end
                    assign win_grid[r][c][d] = (&occ) && ((&own) || !(|own));
                end else begin : g_out
                    assign win_grid[r][c][d] = 1'b0;
                end
            end
        end
    end

    assign win   = win_grid[row][col];
    assign owner = {4{own_grid[row][col]}};

endmodule

// File: rtl/win_scanner.sv
// Sequential Connect-4 win detector: snapshots the board on start, then scans one anchor per clock.
module win_scanner
    import connect_pkg::*;
#(
    parameter int unsigned ROWS    = 6,
    parameter int unsigned COLS    = 7,
    parameter int unsigned WIN_LEN = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [ROWS*COLS-1:0]         game_board,
    input  logic [ROWS*COLS-1:0]         player_cells,
    output logic                         busy,
    output logic                         done,
    output logic [1:0]                   game_status,
    output logic [$clog2(ROWS*COLS)-1:0] win_anchor,
    output logic [1:0]                   win_dir
);

    localparam int unsigned CELLS = ROWS * COLS;
    localparam int unsigned IW    = $clog2(CELLS);
    localparam int unsigned RW    = idx_width(ROWS);
    localparam int unsigned CW    = idx_width(COLS);
    localparam int unsigned MAXD  = (ROWS > COLS) ? ROWS : COLS;
    localparam logic [IW-1:0] LAST_IDX = IW'(CELLS - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

    if (WIN_LEN < 2 || WIN_LEN > MAXD) begin : g_bad_win_len
        $error("win_scanner: WIN_LEN must lie in 2..max(ROWS, COLS)");
    end

    scan_state_e      state;
    logic [CELLS-1:0] snap_board;
    logic [CELLS-1:0] snap_owner;
    logic [IW-1:0]    idx;
    logic [RW-1:0]    row;
    logic [CW-1:0]    col;

    logic [3:0] win;
    logic [3:0] owner;
    logic       hit;
    logic [1:0] hit_dir;
    logic       hit_owner;

    win_line_eval #(
        .ROWS    (ROWS),
        .COLS    (COLS),
        .WIN_LEN (WIN_LEN),
        .RW      (RW),
        .CW      (CW)
    ) u_eval (
        .snap_board (snap_board),
        .snap_owner (snap_owner),
        .row        (row),
        .col        (col),
        .win        (win),
        .owner      (owner)
    );

    always_comb begin
        hit     = |win;
        hit_dir = DIR_H;
        if (win[0])      hit_dir = DIR_H;
        else if (win[1]) hit_dir = DIR_V;
        else if (win[2]) hit_dir = DIR_DR;
        else if (win[3]) hit_dir = DIR_DL;
        hit_owner = owner[hit_dir];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= StIdle;
            busy        <= 1'b0;
            done        <= 1'b0;
            game_status <= STILL_PLAYING;
            win_anchor  <= '0;
            win_dir     <= DIR_H;
            idx         <= '0;
            row         <= '0;
            col         <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        snap_board <= game_board;
                        snap_owner <= player_cells;
                        idx        <= '0;
                        row        <= '0;
                        col        <= '0;
                        busy       <= 1'b1;
                        state      <= StScan;
                    end
                end
                StScan: begin
                    if (hit) begin
                        game_status <= hit_owner ? P2_WINS : P1_WINS;
                        win_anchor  <= idx;
                        win_dir     <= hit_dir;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state       <= StIdle;
                    end else if (idx == LAST_IDX) begin
                        game_status <= (&snap_board) ? TIE : STILL_PLAYING;
                        win_anchor  <= '0;
                        win_dir     <= DIR_H;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state       <= StIdle;
                    end else begin
                        idx <= idx + 1'b1;
                        // Separate row/col counters avoid dividing the anchor index.
                        if (col == LAST_COL) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_win_scanner.sv
// Directed bench for win_scanner: default 6x7 board plus a 4x4 legacy instance.
module tb_win_scanner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [41:0] board;
    logic [41:0] owner;
    logic        busy;
    logic        done;
    logic [1:0]  status;
    logic [5:0]  anchor;
    logic [1:0]  dir;

    logic        l_start;
    logic [15:0] l_board;
    logic [15:0] l_owner;
    logic        l_busy;
    logic        l_done;
    logic [1:0]  l_status;
    logic [3:0]  l_anchor;
    logic [1:0]  l_dir;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    win_scanner dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .game_board   (board),
        .player_cells (owner),
        .busy         (busy),
        .done         (done),
        .game_status  (status),
        .win_anchor   (anchor),
        .win_dir      (dir)
    );

    win_scanner #(
        .ROWS    (4),
        .COLS    (4),
        .WIN_LEN (4)
    ) dut_legacy (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (l_start),
        .game_board   (l_board),
        .player_cells (l_owner),
        .busy         (l_busy),
        .done         (l_done),
        .game_status  (l_status),
        .win_anchor   (l_anchor),
        .win_dir      (l_dir)
    );

    function automatic logic [41:0] vert_p1();
        logic [41:0] b;
        b = '0;
        b[0] = 1'b1; b[7] = 1'b1; b[14] = 1'b1; b[21] = 1'b1;
        return b;
    endfunction

    function automatic logic [41:0] horiz_row5();
        logic [41:0] b;
        b = '0;
        b[38:35] = 4'hF;
        return b;
    endfunction

    // Stimulus only: issues start, returns cycles from start edge to the done edge (-1 on timeout).
    task automatic do_scan(input logic [41:0] b, input logic [41:0] o, output int lat);
        @(negedge clk);
        board = b;
        owner = o;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; board = '0; owner = '0;
        l_start = 1'b0; l_board = '0; l_owner = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (status !== 2'b00) begin bad++; $display("FAIL reset_status got=%b want=00", status); end
        total++; if (anchor !== 6'd0) begin bad++; $display("FAIL reset_anchor got=%0d want=0", anchor); end
        total++; if (dir !== 2'b00) begin bad++; $display("FAIL reset_dir got=%b want=00", dir); end
        total++; if (l_status !== 2'b00 || l_busy !== 1'b0) begin
            bad++; $display("FAIL reset_legacy got status=%b busy=%b want 00/0", l_status, l_busy);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_vertical_p1();
        int lat;
        do_scan(vert_p1(), '0, lat);
        total++; if (lat !== 1) begin bad++; $display("FAIL vert_latency got=%0d want=1", lat); end
        total++; if (status !== 2'b01) begin bad++; $display("FAIL vert_status got=%b want=01", status); end
        total++; if (anchor !== 6'd0) begin bad++; $display("FAIL vert_anchor got=%0d want=0", anchor); end
        total++; if (dir !== 2'b01) begin bad++; $display("FAIL vert_dir got=%b want=01", dir); end
    endtask

    task automatic test_horizontal_p2();
        int lat;
        do_scan(horiz_row5(), horiz_row5(), lat);
        total++; if (lat !== 36) begin bad++; $display("FAIL horiz_latency got=%0d want=36", lat); end
        total++; if (status !== 2'b10) begin bad++; $display("FAIL horiz_status got=%b want=10", status); end
        total++; if (anchor !== 6'd35) begin bad++; $display("FAIL horiz_anchor got=%0d want=35", anchor); end
        total++; if (dir !== 2'b00) begin bad++; $display("FAIL horiz_dir got=%b want=00", dir); end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL horiz_done_pulse got=%b want=0", done); end
        total++; if (status !== 2'b10) begin bad++; $display("FAIL horiz_hold got=%b want=10", status); end
    endtask

    task automatic test_priority();
        int lat;
        logic [41:0] b;
        b = horiz_row5();
        b[3] = 1'b1; b[9] = 1'b1; b[15] = 1'b1; b[21] = 1'b1;
        do_scan(b, horiz_row5(), lat);
        total++; if (lat !== 4) begin bad++; $display("FAIL prio_latency got=%0d want=4", lat); end
        total++; if (status !== 2'b01) begin bad++; $display("FAIL prio_status got=%b want=01", status); end
        total++; if (anchor !== 6'd3) begin bad++; $display("FAIL prio_anchor got=%0d want=3", anchor); end
        total++; if (dir !== 2'b11) begin bad++; $display("FAIL prio_dir got=%b want=11", dir); end
    endtask

    task automatic test_tie();
        int lat;
        logic [41:0] o;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 7; c++)
                o[r*7+c] = 1'(((c >> 1) + r) & 1);
        do_scan('1, o, lat);
        total++; if (lat !== 42) begin bad++; $display("FAIL tie_latency got=%0d want=42", lat); end
        total++; if (status !== 2'b11) begin bad++; $display("FAIL tie_status got=%b want=11", status); end
        total++; if (anchor !== 6'd0) begin bad++; $display("FAIL tie_anchor got=%0d want=0", anchor); end
    endtask

    task automatic test_edge_wrap();
        int lat;
        logic [41:0] b;
        b = '0;
        b[8:5] = 4'hF;
        do_scan(b, '0, lat);
        total++; if (lat !== 42) begin bad++; $display("FAIL wrap_latency got=%0d want=42", lat); end
        total++; if (status !== 2'b00) begin bad++; $display("FAIL wrap_status got=%b want=00", status); end
    endtask

    task automatic test_empty();
        int lat;
        do_scan(vert_p1(), '0, lat);
        do_scan('0, '0, lat);
        total++; if (lat !== 42) begin bad++; $display("FAIL empty_latency got=%0d want=42", lat); end
        total++; if (status !== 2'b00) begin bad++; $display("FAIL empty_status got=%b want=00", status); end
        total++; if (dir !== 2'b00) begin bad++; $display("FAIL empty_dir got=%b want=00", dir); end
    endtask

    task automatic test_start_while_busy();
        int dones;
        int done_at;
        dones = 0;
        done_at = -1;
        @(negedge clk);
        board = '0; owner = '0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                dones++;
                done_at = n;
            end
            if (n == 4) begin
                start = 1'b1;
                board = vert_p1();
            end else begin
                start = 1'b0;
            end
        end
        total++; if (dones !== 1) begin bad++; $display("FAIL busy_start_dones got=%0d want=1", dones); end
        total++; if (done_at !== 42) begin bad++; $display("FAIL busy_start_lat got=%0d want=42", done_at); end
        total++; if (status !== 2'b00) begin bad++; $display("FAIL busy_start_status got=%b want=00", status); end
    endtask

    task automatic test_reset_mid_scan();
        int lat;
        int dones;
        do_scan(horiz_row5(), horiz_row5(), lat);
        total++; if (status !== 2'b10) begin bad++; $display("FAIL rst_pre_status got=%b want=10", status); end
        @(negedge clk);
        board = '0; owner = '0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b want=0", busy); end
        total++; if (status !== 2'b00) begin bad++; $display("FAIL rst_mid_status got=%b want=00", status); end
        total++; if (anchor !== 6'd0) begin bad++; $display("FAIL rst_mid_anchor got=%0d want=0", anchor); end
        total++; if (dir !== 2'b00 || done !== 1'b0) begin
            bad++; $display("FAIL rst_mid_dir_done got dir=%b done=%b want 00/0", dir, done);
        end
        rst_n = 1'b1;
        dones = 0;
        repeat (50) begin
            @(posedge clk);
            @(negedge clk);
            if (done) dones++;
        end
        total++; if (dones !== 0) begin bad++; $display("FAIL rst_mid_no_done got=%0d want=0", dones); end
        do_scan(vert_p1(), '0, lat);
        total++; if (lat !== 1) begin bad++; $display("FAIL rst_fresh_latency got=%0d want=1", lat); end
        total++; if (status !== 2'b01) begin bad++; $display("FAIL rst_fresh_status got=%b want=01", status); end
    endtask

    task automatic test_back_to_back();
        int  lat;
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        board = vert_p1(); owner = '0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL b2b_first_done got=%b want=1", seen); end
        board = horiz_row5(); owner = horiz_row5(); start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept_busy got=%b want=1", busy); end
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                lat = n;
                break;
            end
        end
        total++; if (lat !== 36) begin bad++; $display("FAIL b2b_latency got=%0d want=36", lat); end
        total++; if (status !== 2'b10) begin bad++; $display("FAIL b2b_status got=%b want=10", status); end
    endtask

    task automatic legacy_scan(input logic [15:0] b, input logic [15:0] o, output int lat);
        @(negedge clk);
        l_board = b; l_owner = o; l_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        l_start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (l_done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_legacy();
        int lat;
        // Full board with rows 0-2 owned by P1: top-row H at anchor 0 comes first.
        legacy_scan(16'hFFFF, 16'hF000, lat);
        total++; if (lat !== 1) begin bad++; $display("FAIL legacy_full_latency got=%0d want=1", lat); end
        total++; if (l_status !== 2'b01 || l_anchor !== 4'd0 || l_dir !== 2'b00) begin
            bad++; $display("FAIL legacy_full got st=%b an=%0d dir=%b want 01/0/00", l_status, l_anchor, l_dir);
        end
        // Rows 0-2 striped so only bottom row wins for P2.
        legacy_scan(16'hFFFF, 16'hFC3C, lat);
        total++; if (lat !== 13) begin bad++; $display("FAIL legacy_row3_latency got=%0d want=13", lat); end
        total++; if (l_status !== 2'b10 || l_anchor !== 4'd12 || l_dir !== 2'b00) begin
            bad++; $display("FAIL legacy_row3 got st=%b an=%0d dir=%b want 10/12/00", l_status, l_anchor, l_dir);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_vertical_p1();
        test_horizontal_p2();
        test_priority();
        test_tie();
        test_edge_wrap();
        test_empty();
        test_start_while_busy();
        test_reset_mid_scan();
        test_back_to_back();
        test_legacy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
